// File: rtl/dcache_load_formatter.sv
`default_nettype none
// ============================================================================
// Module   : dcache_load_formatter
// Purpose  : Aligns and extends cache load data and merges LWL/LWR results.
//            Formatted results wait in a small in-order output queue.
// Revision : 1.0 - initial release
// ============================================================================
module dcache_load_formatter #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 6,
    parameter int DEPTH  = 2
) (
    input  logic                               clk,
    input  logic                               resetn,
    input  logic                               flush,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [1:0]                         in_size,
    input  logic                               in_sign,
    input  logic [1:0]                         in_lr,
    input  logic [$clog2(DATA_W/8)-1:0]        in_addr,
    input  logic [DATA_W-1:0]                  in_rdata,
    input  logic [DATA_W-1:0]                  in_rt,
    input  logic [TAG_W-1:0]                   in_tag,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [DATA_W-1:0]                  out_data,
    output logic [TAG_W-1:0]                   out_tag,
    output logic                               out_err
);

    localparam int OFF_W   = $clog2(DATA_W / 8);
    localparam int c_cnt_w = $clog2(DEPTH + 1);
    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_cnt_w-1:0] c_depth    = c_cnt_w'(DEPTH);
    localparam logic [c_ptr_w-1:0] c_last_ptr = c_ptr_w'(DEPTH - 1);

    logic [DATA_W-1:0] w_lane;
    logic [31:0]       w_word;
    logic [31:0]       w_merge;
    logic [DATA_W-1:0] w_fmt_data;
    logic              w_fmt_err;
    logic              w_push;
    logic              w_pop;

    logic [DATA_W-1:0]  r_data [DEPTH];
    logic [TAG_W-1:0]   r_tag  [DEPTH];
    logic               r_err  [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;

    // Aligned accesses only reach the extension logic, so one byte shifter serves all sizes.
    assign w_lane = in_rdata >> {in_addr, 3'b000};

    generate
        if (DATA_W == 64) begin : g_word64
            assign w_word = in_addr[OFF_W-1] ? in_rdata[DATA_W-1:32] : in_rdata[31:0];
        end else begin : g_word32
            assign w_word = in_rdata[31:0];
        end
    endgenerate

    always_comb begin
        w_merge = w_word;
        if (in_lr == 2'b10) begin
            case (in_addr[1:0])
                2'd0:    w_merge = {w_word[7:0],  in_rt[23:0]};
                2'd1:    w_merge = {w_word[15:0], in_rt[15:0]};
                2'd2:    w_merge = {w_word[23:0], in_rt[7:0]};
                default: w_merge = w_word;
            endcase
        end else begin
            case (in_addr[1:0])
                2'd0:    w_merge = w_word;
                2'd1:    w_merge = {in_rt[31:24], w_word[31:8]};
                2'd2:    w_merge = {in_rt[31:16], w_word[31:16]};
                default: w_merge = {in_rt[31:8],  w_word[31:24]};
            endcase
        end
    end

    always_comb begin
        w_fmt_err  = 1'b0;
        w_fmt_data = '0;
        if (in_lr == 2'b11) begin
            w_fmt_err = 1'b1;
        end else if (in_lr != 2'b00) begin
            w_fmt_data = DATA_W'($signed(w_merge));
        end else begin
            case (in_size)
                2'd0: w_fmt_data = in_sign ? DATA_W'($signed(w_lane[7:0])) : DATA_W'(w_lane[7:0]);
                2'd1: begin
                    if (in_addr[0])
                        w_fmt_err = 1'b1;
                    else
                        w_fmt_data = in_sign ? DATA_W'($signed(w_lane[15:0])) : DATA_W'(w_lane[15:0]);
                end
                2'd2: begin
                    if (in_addr[1:0] != 2'b00)
                        w_fmt_err = 1'b1;
                    else
                        w_fmt_data = in_sign ? DATA_W'($signed(w_lane[31:0])) : DATA_W'(w_lane[31:0]);
                end
                default: begin
                    if (DATA_W != 64 || in_addr != '0)
                        w_fmt_err = 1'b1;
                    else
                        w_fmt_data = in_rdata;
                end
            endcase
        end
    end

    // in_ready depends only on occupancy, so a full queue stalls even while popping.
    assign in_ready  = resetn && (r_count < c_depth);
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready && !flush;
    assign w_pop     = out_valid && out_ready && !flush;

    assign out_data = r_data[r_rd_ptr];
    assign out_tag  = r_tag[r_rd_ptr];
    assign out_err  = r_err[r_rd_ptr];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
                r_tag[i]  <= '0;
                r_err[i]  <= 1'b0;
            end
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_data[r_wr_ptr] <= w_fmt_data;
                r_tag[r_wr_ptr]  <= in_tag;
                r_err[r_wr_ptr]  <= w_fmt_err;
                r_wr_ptr         <= (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop)
                r_count <= r_count + 1'b1;
            else if (!w_push && w_pop)
                r_count <= r_count - 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dcache_load_formatter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache_load_formatter
// Purpose  : Self-checking bench for a 32-bit/depth-2 and a 64-bit/depth-3 instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dcache_load_formatter;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // 32-bit instance, DEPTH=2
    logic        a_flush, a_in_valid, a_in_ready, a_in_sign, a_out_valid, a_out_ready, a_out_err;
    logic [1:0]  a_in_size, a_in_lr, a_in_addr;
    logic [31:0] a_in_rdata, a_in_rt, a_out_data;
    logic [5:0]  a_in_tag, a_out_tag;

    // 64-bit instance, DEPTH=3
    logic        b_flush, b_in_valid, b_in_ready, b_in_sign, b_out_valid, b_out_ready, b_out_err;
    logic [1:0]  b_in_size, b_in_lr;
    logic [2:0]  b_in_addr;
    logic [63:0] b_in_rdata, b_in_rt, b_out_data;
    logic [5:0]  b_in_tag, b_out_tag;

    dcache_load_formatter #(.DATA_W(32), .TAG_W(6), .DEPTH(2)) u_a (
        .clk(clk), .resetn(resetn), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_size(a_in_size), .in_sign(a_in_sign),
        .in_lr(a_in_lr), .in_addr(a_in_addr), .in_rdata(a_in_rdata), .in_rt(a_in_rt), .in_tag(a_in_tag),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_tag(a_out_tag), .out_err(a_out_err)
    );

    dcache_load_formatter #(.DATA_W(64), .TAG_W(6), .DEPTH(3)) u_b (
        .clk(clk), .resetn(resetn), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_size(b_in_size), .in_sign(b_in_sign),
        .in_lr(b_in_lr), .in_addr(b_in_addr), .in_rdata(b_in_rdata), .in_rt(b_in_rt), .in_tag(b_in_tag),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_tag(b_out_tag), .out_err(b_out_err)
    );

    // Reference: returns {err, data}, built byte by byte from the load rules.
    function automatic logic [64:0] ref_fmt(input int dw, input logic [1:0] size, input logic sign,
                                            input logic [1:0] lr, input int addr,
                                            input logic [63:0] rdata, input logic [63:0] rt);
        logic [63:0] r;
        logic [31:0] w, x;
        int nb, a;
        r = '0;
        if (lr == 2'b11) return {1'b1, 64'd0};
        if (lr == 2'b00) begin
            nb = 1 << size;
            if (nb * 8 > dw || (addr % nb) != 0) return {1'b1, 64'd0};
            for (int i = 0; i < nb; i++) r[8*i +: 8] = rdata[8*(addr+i) +: 8];
            if (sign) for (int k = nb * 8; k < dw; k++) r[k] = r[nb*8-1];
            return {1'b0, r};
        end
        w = (dw == 64 && addr >= 4) ? rdata[63:32] : rdata[31:0];
        a = addr % 4;
        x = rt[31:0];
        if (lr == 2'b10) for (int k = 0; k <= a; k++) x[8*(3-a+k) +: 8] = w[8*k +: 8];
        else             for (int k = 0; k <= 3 - a; k++) x[8*k +: 8] = w[8*(k+a) +: 8];
        r = {{32{x[31]}}, x};
        if (dw == 32) r[63:32] = '0;
        return {1'b0, r};
    endfunction

    function automatic logic [1:0] pick_lr();
        int v;
        v = $urandom_range(0, 7);
        if (v == 5) return 2'b10;
        if (v == 6) return 2'b01;
        if (v == 7) return 2'b11;
        return 2'b00;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_set(input logic [1:0] size, input logic sign, input logic [1:0] lr, input logic [1:0] addr,
                         input logic [31:0] rdata, input logic [31:0] rt, input logic [5:0] tag);
        a_in_size = size; a_in_sign = sign; a_in_lr = lr; a_in_addr = addr;
        a_in_rdata = rdata; a_in_rt = rt; a_in_tag = tag; a_in_valid = 1'b1;
    endtask

    task automatic b_set(input logic [1:0] size, input logic sign, input logic [1:0] lr, input logic [2:0] addr,
                         input logic [63:0] rdata, input logic [63:0] rt, input logic [5:0] tag);
        b_in_size = size; b_in_sign = sign; b_in_lr = lr; b_in_addr = addr;
        b_in_rdata = rdata; b_in_rt = rt; b_in_tag = tag; b_in_valid = 1'b1;
    endtask

    task automatic test_reset();
        #3;
        n_tests++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b0 || a_out_data !== 32'd0 ||
            a_out_tag !== 6'd0 || a_out_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_a: got valid=%b ready=%b data=%h tag=%h err=%b, want all 0",
                     a_out_valid, a_in_ready, a_out_data, a_out_tag, a_out_err);
        end
        n_tests++;
        if (b_out_valid !== 1'b0 || b_in_ready !== 1'b0 || b_out_data !== 64'd0 ||
            b_out_tag !== 6'd0 || b_out_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_b: got valid=%b ready=%b data=%h tag=%h err=%b, want all 0",
                     b_out_valid, b_in_ready, b_out_data, b_out_tag, b_out_err);
        end
        tick();
        @(negedge clk);
        resetn = 1'b1;
        #1;
        n_tests++;
        if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: got a_ready=%b b_ready=%b, want 1 1", a_in_ready, b_in_ready);
        end
        tick();
    endtask

    task automatic test_byte_lanes();
        logic [31:0] exp_d [3];
        logic [1:0]  addr  [3];
        logic        sgn   [3];
        // Byte 1 of 0x80FF7F01 is 0x7F with bit 7 clear, so sign extension fills zeros.
        exp_d = '{32'h0000007F, 32'hFFFFFF80, 32'h00000080};
        addr  = '{2'd1, 2'd3, 2'd3};
        sgn   = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            a_out_ready = 1'b0;
            a_set(2'd0, sgn[i], 2'b00, addr[i], 32'h80FF7F01, 32'h0, 6'(i + 1));
            tick();
            a_in_valid = 1'b0;
            n_tests++;
            if (a_out_valid !== 1'b1 || a_out_data !== exp_d[i] || a_out_err !== 1'b0) begin
                n_fail++;
                $display("FAIL byte_lane[%0d]: got valid=%b data=%h err=%b, want valid=1 data=%h err=0",
                         i, a_out_valid, a_out_data, a_out_err, exp_d[i]);
            end
            a_out_ready = 1'b1;
            tick();
            a_out_ready = 1'b0;
        end
        n_tests++;
        if (a_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL byte_drain: got valid=%b, want 0", a_out_valid);
        end
    endtask

    task automatic test_lwl_lwr();
        logic [31:0] exp_d [2];
        logic [1:0]  lr    [2];
        logic [1:0]  addr  [2];
        exp_d = '{32'h2211CCDD, 32'hAABB4433};
        lr    = '{2'b10, 2'b01};
        addr  = '{2'd1, 2'd2};
        for (int i = 0; i < 2; i++) begin
            a_set(2'd2, 1'b0, lr[i], addr[i], 32'h44332211, 32'hAABBCCDD, 6'(10 + i));
            tick();
            a_in_valid = 1'b0;
            n_tests++;
            if (a_out_valid !== 1'b1 || a_out_data !== exp_d[i] || a_out_err !== 1'b0) begin
                n_fail++;
                $display("FAIL lwl_lwr[%0d]: got valid=%b data=%h err=%b, want valid=1 data=%h err=0",
                         i, a_out_valid, a_out_data, a_out_err, exp_d[i]);
            end
            a_out_ready = 1'b1;
            tick();
            a_out_ready = 1'b0;
        end
    endtask

    task automatic test_errors();
        logic [1:0] size [3];
        logic [1:0] lr   [3];
        logic [1:0] addr [3];
        size = '{2'd1, 2'd2, 2'd3};
        lr   = '{2'b00, 2'b11, 2'b00};
        addr = '{2'd1, 2'd0, 2'd0};
        for (int i = 0; i < 3; i++) begin
            a_set(size[i], 1'b1, lr[i], addr[i], 32'hDEADBEEF, 32'h12345678, 6'(20 + i));
            tick();
            a_in_valid = 1'b0;
            n_tests++;
            if (a_out_valid !== 1'b1 || a_out_err !== 1'b1 || a_out_data !== 32'd0 ||
                a_out_tag !== 6'(20 + i)) begin
                n_fail++;
                $display("FAIL error[%0d]: got valid=%b err=%b data=%h tag=%0d, want valid=1 err=1 data=0 tag=%0d",
                         i, a_out_valid, a_out_err, a_out_data, a_out_tag, 20 + i);
            end
            a_out_ready = 1'b1;
            tick();
            a_out_ready = 1'b0;
        end
    endtask

    task automatic test_w64();
        logic [63:0] exp_d [3];
        logic [1:0]  size  [3];
        logic [2:0]  addr  [3];
        logic        sgn   [3];
        exp_d = '{64'hFFFFFFFF88776655, 64'h0000000088776655, 64'h8877665544332211};
        size  = '{2'd2, 2'd2, 2'd3};
        addr  = '{3'd4, 3'd4, 3'd0};
        sgn   = '{1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            b_out_ready = 1'b0;
            b_set(size[i], sgn[i], 2'b00, addr[i], 64'h8877665544332211, 64'h0, 6'(30 + i));
            tick();
            b_in_valid = 1'b0;
            n_tests++;
            if (b_out_valid !== 1'b1 || b_out_data !== exp_d[i] || b_out_err !== 1'b0) begin
                n_fail++;
                $display("FAIL w64[%0d]: got valid=%b data=%h err=%b, want valid=1 data=%h err=0",
                         i, b_out_valid, b_out_data, b_out_err, exp_d[i]);
            end
            b_out_ready = 1'b1;
            tick();
            b_out_ready = 1'b0;
        end
    endtask

    task automatic test_backpressure();
        a_out_ready = 1'b0;
        a_set(2'd0, 1'b0, 2'b00, 2'd0, $urandom, $urandom, 6'd1);
        tick();
        a_set(2'd0, 1'b0, 2'b00, 2'd1, $urandom, $urandom, 6'd2);
        tick();
        n_tests++;
        if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1 || a_out_tag !== 6'd1) begin
            n_fail++;
            $display("FAIL bp_full: got ready=%b valid=%b tag=%0d, want ready=0 valid=1 tag=1",
                     a_in_ready, a_out_valid, a_out_tag);
        end
        a_set(2'd0, 1'b0, 2'b00, 2'd2, $urandom, $urandom, 6'd3);
        a_out_ready = 1'b1;
        tick();
        a_in_valid = 1'b0;
        n_tests++;
        if (a_out_valid !== 1'b1 || a_out_tag !== 6'd2 || a_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_pop_while_full: got valid=%b tag=%0d ready=%b, want valid=1 tag=2 ready=1",
                     a_out_valid, a_out_tag, a_in_ready);
        end
        tick();
        n_tests++;
        if (a_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_stalled_push: got valid=%b, want 0", a_out_valid);
        end
        a_set(2'd0, 1'b0, 2'b00, 2'd3, $urandom, $urandom, 6'd4);
        tick();
        n_tests++;
        if (a_out_valid !== 1'b1 || a_out_tag !== 6'd4) begin
            n_fail++;
            $display("FAIL bp_wrap_first: got valid=%b tag=%0d, want valid=1 tag=4", a_out_valid, a_out_tag);
        end
        a_set(2'd0, 1'b0, 2'b00, 2'd0, $urandom, $urandom, 6'd5);
        tick();
        a_in_valid = 1'b0;
        n_tests++;
        if (a_out_valid !== 1'b1 || a_out_tag !== 6'd5) begin
            n_fail++;
            $display("FAIL bp_wrap_second: got valid=%b tag=%0d, want valid=1 tag=5", a_out_valid, a_out_tag);
        end
        tick();
        a_out_ready = 1'b0;
        n_tests++;
        if (a_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drain: got valid=%b, want 0", a_out_valid);
        end
    endtask

    task automatic test_flush();
        b_out_ready = 1'b0;
        b_set(2'd3, 1'b0, 2'b00, 3'd0, 64'h1, 64'h0, 6'd40);
        tick();
        b_set(2'd3, 1'b0, 2'b00, 3'd0, 64'h2, 64'h0, 6'd41);
        tick();
        b_set(2'd3, 1'b0, 2'b00, 3'd0, 64'h3, 64'h0, 6'd42);
        b_flush = 1'b1;
        b_out_ready = 1'b1;
        tick();
        b_flush = 1'b0;
        b_in_valid = 1'b0;
        b_out_ready = 1'b0;
        n_tests++;
        if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush: got valid=%b ready=%b, want valid=0 ready=1", b_out_valid, b_in_ready);
        end
        tick();
        n_tests++;
        if (b_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_push_dropped: got valid=%b, want 0", b_out_valid);
        end
    endtask

    task automatic test_reset_midstream();
        a_out_ready = 1'b0;
        b_out_ready = 1'b0;
        a_set(2'd2, 1'b0, 2'b00, 2'd0, 32'hCAFEF00D, 32'h0, 6'd50);
        b_set(2'd3, 1'b0, 2'b00, 3'd0, 64'h0123456789ABCDEF, 64'h0, 6'd51);
        tick();
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        n_tests++;
        if (a_out_valid !== 1'b1 || b_out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_setup: got a_valid=%b b_valid=%b, want 1 1", a_out_valid, b_out_valid);
        end
        #1;
        resetn = 1'b0;
        #1;
        n_tests++;
        if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0 || a_in_ready !== 1'b0 ||
            a_out_data !== 32'd0 || b_out_data !== 64'd0) begin
            n_fail++;
            $display("FAIL midreset_async: got a_valid=%b b_valid=%b a_ready=%b a_data=%h b_data=%h, want 0 0 0 0 0",
                     a_out_valid, b_out_valid, a_in_ready, a_out_data, b_out_data);
        end
        @(negedge clk);
        resetn = 1'b1;
        #1;
        n_tests++;
        if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_release: got a_ready=%b b_ready=%b a_valid=%b, want 1 1 0",
                     a_in_ready, b_in_ready, a_out_valid);
        end
        tick();
    endtask

    task automatic test_random();
        logic [70:0] qa [$];
        logic [70:0] qb [$];
        logic [70:0] got;
        logic [64:0] m;
        bit          acc;
        for (int c = 0; c < 400; c++) begin
            a_in_valid = ($urandom_range(0, 2) != 0);
            a_out_ready = ($urandom_range(0, 3) != 0);
            a_flush = ($urandom_range(0, 31) == 0);
            a_in_size = 2'($urandom_range(0, 3));
            a_in_sign = 1'($urandom_range(0, 1));
            a_in_lr = pick_lr();
            a_in_addr = 2'($urandom_range(0, 3));
            a_in_rdata = $urandom;
            a_in_rt = $urandom;
            a_in_tag = 6'($urandom);
            b_in_valid = ($urandom_range(0, 2) != 0);
            b_out_ready = ($urandom_range(0, 3) != 0);
            b_flush = ($urandom_range(0, 31) == 0);
            b_in_size = 2'($urandom_range(0, 3));
            b_in_sign = 1'($urandom_range(0, 1));
            b_in_lr = pick_lr();
            b_in_addr = 3'($urandom_range(0, 7));
            b_in_rdata = {$urandom, $urandom};
            b_in_rt = {$urandom, $urandom};
            b_in_tag = 6'($urandom);
            #1;

            n_tests++;
            if (a_out_valid !== (qa.size() != 0) || a_in_ready !== (qa.size() < 2)) begin
                n_fail++;
                $display("FAIL rand_a_flags[%0d]: got valid=%b ready=%b, want valid=%b ready=%b",
                         c, a_out_valid, a_in_ready, qa.size() != 0, qa.size() < 2);
            end
            acc = (qa.size() < 2);
            if (a_out_ready && !a_flush && qa.size() > 0) begin
                got = {a_out_err, a_out_tag, 32'd0, a_out_data};
                n_tests++;
                if (got !== qa[0]) begin
                    n_fail++;
                    $display("FAIL rand_a_data[%0d]: got err=%b tag=%0d data=%h, want err=%b tag=%0d data=%h",
                             c, a_out_err, a_out_tag, a_out_data, qa[0][70], qa[0][69:64], qa[0][31:0]);
                end
                void'(qa.pop_front());
            end
            if (a_in_valid && acc && !a_flush) begin
                m = ref_fmt(32, a_in_size, a_in_sign, a_in_lr, int'(a_in_addr),
                            {32'd0, a_in_rdata}, {32'd0, a_in_rt});
                qa.push_back({m[64], a_in_tag, m[63:0]});
            end
            if (a_flush) qa.delete();

            n_tests++;
            if (b_out_valid !== (qb.size() != 0) || b_in_ready !== (qb.size() < 3)) begin
                n_fail++;
                $display("FAIL rand_b_flags[%0d]: got valid=%b ready=%b, want valid=%b ready=%b",
                         c, b_out_valid, b_in_ready, qb.size() != 0, qb.size() < 3);
            end
            acc = (qb.size() < 3);
            if (b_out_ready && !b_flush && qb.size() > 0) begin
                got = {b_out_err, b_out_tag, b_out_data};
                n_tests++;
                if (got !== qb[0]) begin
                    n_fail++;
                    $display("FAIL rand_b_data[%0d]: got err=%b tag=%0d data=%h, want err=%b tag=%0d data=%h",
                             c, b_out_err, b_out_tag, b_out_data, qb[0][70], qb[0][69:64], qb[0][63:0]);
                end
                void'(qb.pop_front());
            end
            if (b_in_valid && acc && !b_flush) begin
                m = ref_fmt(64, b_in_size, b_in_sign, b_in_lr, int'(b_in_addr), b_in_rdata, b_in_rt);
                qb.push_back({m[64], b_in_tag, m[63:0]});
            end
            if (b_flush) qb.delete();

            tick();
        end
        a_in_valid = 1'b0; a_out_ready = 1'b0; a_flush = 1'b0;
        b_in_valid = 1'b0; b_out_ready = 1'b0; b_flush = 1'b0;
    endtask

    initial begin
        a_flush = 1'b0; a_in_valid = 1'b0; a_in_size = '0; a_in_sign = 1'b0; a_in_lr = '0;
        a_in_addr = '0; a_in_rdata = '0; a_in_rt = '0; a_in_tag = '0; a_out_ready = 1'b0;
        b_flush = 1'b0; b_in_valid = 1'b0; b_in_size = '0; b_in_sign = 1'b0; b_in_lr = '0;
        b_in_addr = '0; b_in_rdata = '0; b_in_rt = '0; b_in_tag = '0; b_out_ready = 1'b0;

        test_reset();
        test_byte_lanes();
        test_lwl_lwr();
        test_errors();
        test_w64();
        test_backpressure();
        test_flush();
        test_reset_midstream();
        test_random();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
